id_ex_stage: RTL and testbench

//  ID/EX pipeline register of the 5-stage MIPS core, with load-use hazard detection and bubble/flush control.

---
 rtl/mips_pipe_pkg.sv | 14 +
 rtl/load_use_detect.sv | 24 ++
 rtl/id_ex_stage.sv | 89 ++++++++
 tb/tb_id_ex_stage.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared constants of the 5-stage MIPS pipeline: control-bundle bit map and register ids.
// No logic, so no latency or backpressure.
package mips_pipe_pkg;
   localparam int CTRL_W         = 9;
   localparam int CTRL_REG_WRITE = 0;
   localparam int CTRL_MEM_READ  = 1;
   localparam int CTRL_MEM_WRITE = 2;
   localparam int CTRL_MEM_TO_REG = 3;
   localparam int CTRL_ALU_SRC   = 4;
   localparam int CTRL_REG_DST   = 5;
   localparam int CTRL_ALU_OP    = 6;
   localparam int CTRL_ALU_OP_W  = 2;
   localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: a load in EX whose target the ID instruction reads.
// Purely combinational, 0-cycle latency; no backpressure of its own.
module load_use_detect
   import mips_pipe_pkg::*;
(
   input  logic       ex_valid,
   input  logic       ex_mem_read,
   input  logic [4:0] ex_rt,
   input  logic       id_valid,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rs,
   input  logic       id_uses_rt,
   output logic       hazard
);
   logic rs_match;
   logic rt_match;

   assign rs_match = id_uses_rs && (id_rs == ex_rt);
   assign rt_match = id_uses_rt && (id_rt == ex_rt);
   // $0 is hardwired, so a load targeting it never produces a dependency.
   assign hazard   = ex_valid && ex_mem_read && (ex_rt != REG_ZERO) && id_valid &&
                     (rs_match || rt_match);
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and saturating stall counter.
// ID to EX in 1 cycle; stall is combinational and holds PC/IF-ID on load-use or ex_busy, flush overrides.
module id_ex_stage #(
   parameter int CTRL_W = 9,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [4:0]        id_rs,
   input  logic [4:0]        id_rt,
   input  logic [4:0]        id_rd,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic [31:0]       id_rd1,
   input  logic [31:0]       id_rd2,
   input  logic [31:0]       id_imm,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic              flush,
   input  logic              ex_busy,
   output logic              ex_valid,
   output logic [4:0]        ex_rs,
   output logic [4:0]        ex_rt,
   output logic [4:0]        ex_rd,
   output logic [31:0]       ex_rd1,
   output logic [31:0]       ex_rd2,
   output logic [31:0]       ex_imm,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic              stall,
   output logic [CNT_W-1:0]  stall_count
);
   import mips_pipe_pkg::*;

   logic hazard;

   load_use_detect u_detect (
      .ex_valid    (ex_valid),
      .ex_mem_read (ex_ctrl[CTRL_MEM_READ]),
      .ex_rt       (ex_rt),
      .id_valid    (id_valid),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_uses_rs  (id_uses_rs),
      .id_uses_rt  (id_uses_rt),
      .hazard      (hazard)
   );

   assign stall = ~flush & (hazard | ex_busy);

   // Bubbles clear the data fields too, so a killed slot never leaks stale operands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid <= 1'b0;
         ex_rs    <= '0;
         ex_rt    <= '0;
         ex_rd    <= '0;
         ex_rd1   <= '0;
         ex_rd2   <= '0;
         ex_imm   <= '0;
         ex_ctrl  <= '0;
      end else if (flush || (!ex_busy && hazard)) begin
         ex_valid <= 1'b0;
         ex_rs    <= '0;
         ex_rt    <= '0;
         ex_rd    <= '0;
         ex_rd1   <= '0;
         ex_rd2   <= '0;
         ex_imm   <= '0;
         ex_ctrl  <= '0;
      end else if (!ex_busy) begin
         ex_valid <= id_valid;
         ex_rs    <= id_rs;
         ex_rt    <= id_rt;
         ex_rd    <= id_rd;
         ex_rd1   <= id_rd1;
         ex_rd2   <= id_rd2;
         ex_imm   <= id_imm;
         ex_ctrl  <= id_valid ? id_ctrl : '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_count <= '0;
      end else if (stall && (stall_count != {CNT_W{1'b1}})) begin
         stall_count <= stall_count + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: one default build and one 4-bit counter build on shared inputs.
module tb_id_ex_stage;
   localparam logic [8:0] LW_CTRL  = 9'h01B;
   localparam logic [8:0] ADD_CTRL = 9'h0A1;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid, id_uses_rs, id_uses_rt, flush, ex_busy;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic [31:0] id_rd1, id_rd2, id_imm;
   logic [8:0]  id_ctrl;

   logic        ex_valid, stall;
   logic [4:0]  ex_rs, ex_rt, ex_rd;
   logic [31:0] ex_rd1, ex_rd2, ex_imm;
   logic [8:0]  ex_ctrl;
   logic [15:0] stall_count;

   logic        s_valid, s_stall;
   logic [4:0]  s_rs, s_rt, s_rd;
   logic [31:0] s_rd1, s_rd2, s_imm;
   logic [8:0]  s_ctrl;
   logic [3:0]  s_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   id_ex_stage #(.CTRL_W(9), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_rd(id_rd), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd1(id_rd1),
      .id_rd2(id_rd2), .id_imm(id_imm), .id_ctrl(id_ctrl), .flush(flush), .ex_busy(ex_busy),
      .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_rd1(ex_rd1),
      .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl), .stall(stall),
      .stall_count(stall_count)
   );

   id_ex_stage #(.CTRL_W(9), .CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_rd(id_rd), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd1(id_rd1),
      .id_rd2(id_rd2), .id_imm(id_imm), .id_ctrl(id_ctrl), .flush(flush), .ex_busy(ex_busy),
      .ex_valid(s_valid), .ex_rs(s_rs), .ex_rt(s_rt), .ex_rd(s_rd), .ex_rd1(s_rd1),
      .ex_rd2(s_rd2), .ex_imm(s_imm), .ex_ctrl(s_ctrl), .stall(s_stall),
      .stall_count(s_count)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic urs, input logic urt,
                         input logic [31:0] d1, input logic [8:0] c);
      id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rs = urs; id_uses_rt = urt;
      id_rd1 = d1; id_rd2 = ~d1; id_imm = {d1[15:0], 16'h0}; id_ctrl = c;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; flush = 1'b0; ex_busy = 1'b0;
      set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 9'h0);
      step(); step();
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; ex_busy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         set_id(1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom),
                1'($urandom), $urandom, 9'($urandom));
         flush = 1'($urandom);
         step();
      end
      checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ex_valid); end
      checks++; if (ex_ctrl !== 9'h0) begin errors++; $display("FAIL reset_ctrl got %h exp 000", ex_ctrl); end
      checks++; if ({ex_rs, ex_rt, ex_rd} !== 15'h0) begin errors++; $display("FAIL reset_regs got %h exp 0", {ex_rs, ex_rt, ex_rd}); end
      checks++; if ({ex_rd1, ex_rd2, ex_imm} !== 96'h0) begin errors++; $display("FAIL reset_data got %h exp 0", {ex_rd1, ex_rd2, ex_imm}); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
      checks++; if (stall_count !== 16'h0) begin errors++; $display("FAIL reset_count got %h exp 0", stall_count); end
   endtask

   task automatic test_load_use();
      do_reset();
      set_id(1'b1, 5'd2, 5'd8, 5'd0, 1'b1, 1'b0, 32'hA000_0001, LW_CTRL);
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_lw_nostall got %b exp 0", stall); end
      step();
      checks++; if ({ex_valid, ex_rt, ex_ctrl} !== {1'b1, 5'd8, LW_CTRL}) begin errors++; $display("FAIL lu_lw_in_ex got %h exp %h", {ex_valid, ex_rt, ex_ctrl}, {1'b1, 5'd8, LW_CTRL}); end
      set_id(1'b1, 5'd8, 5'd10, 5'd9, 1'b1, 1'b1, 32'hB000_0002, ADD_CTRL);
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %b exp 1", stall); end
      step();
      checks++; if ({ex_valid, ex_ctrl} !== 10'h0) begin errors++; $display("FAIL lu_bubble got %h exp 000", {ex_valid, ex_ctrl}); end
      checks++; if ({ex_rs, ex_rt, ex_rd1} !== 42'h0) begin errors++; $display("FAIL lu_bubble_data got %h exp 0", {ex_rs, ex_rt, ex_rd1}); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_one_bubble got %b exp 0", stall); end
      step();
      checks++; if ({ex_valid, ex_rs, ex_rd, ex_ctrl} !== {1'b1, 5'd8, 5'd9, ADD_CTRL}) begin errors++; $display("FAIL lu_add_in_ex got %h exp %h", {ex_valid, ex_rs, ex_rd, ex_ctrl}, {1'b1, 5'd8, 5'd9, ADD_CTRL}); end
      checks++; if (ex_rd1 !== 32'hB000_0002 || ex_imm !== 32'h0002_0000) begin errors++; $display("FAIL lu_add_data got %h/%h exp b0000002/00020000", ex_rd1, ex_imm); end
      checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL lu_count got %0d exp 1", stall_count); end
   endtask

   task automatic test_no_hazard();
      do_reset();
      set_id(1'b1, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 32'h1, LW_CTRL);
      step();
      set_id(1'b1, 5'd0, 5'd4, 5'd5, 1'b1, 1'b1, 32'h2, ADD_CTRL);
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL zero_stall got %b exp 0", stall); end
      step();
      checks++; if ({ex_valid, ex_rd, ex_ctrl} !== {1'b1, 5'd5, ADD_CTRL}) begin errors++; $display("FAIL zero_nobubble got %h exp %h", {ex_valid, ex_rd, ex_ctrl}, {1'b1, 5'd5, ADD_CTRL}); end
      // Load to $8 in EX, but ID is invalid: no hazard and the bubble carries zero control.
      set_id(1'b1, 5'd3, 5'd8, 5'd0, 1'b1, 1'b0, 32'h3, LW_CTRL);
      step();
      set_id(1'b0, 5'd8, 5'd8, 5'd6, 1'b1, 1'b1, 32'h4, ADD_CTRL);
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL invalid_stall got %b exp 0", stall); end
      step();
      checks++; if ({ex_valid, ex_ctrl} !== 10'h0) begin errors++; $display("FAIL invalid_ctrl got %h exp 000", {ex_valid, ex_ctrl}); end
      checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL nohaz_count got %0d exp 0", stall_count); end
   endtask

   task automatic test_busy();
      do_reset();
      set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 32'h1111_1111, ADD_CTRL);
      step();
      ex_busy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_id(1'b1, 5'(10 + i), 5'(20 + i), 5'(30 - i), 1'b1, 1'b1, 32'hC0 + i, LW_CTRL);
         #1;
         checks++; if (stall !== 1'b1) begin errors++; $display("FAIL busy_stall[%0d] got %b exp 1", i, stall); end
         step();
         checks++; if ({ex_valid, ex_rs, ex_rt, ex_rd, ex_rd1, ex_ctrl} !== {1'b1, 5'd1, 5'd2, 5'd3, 32'h1111_1111, ADD_CTRL}) begin errors++; $display("FAIL busy_hold[%0d] got %h exp %h", i, {ex_valid, ex_rs, ex_rt, ex_rd, ex_rd1, ex_ctrl}, {1'b1, 5'd1, 5'd2, 5'd3, 32'h1111_1111, ADD_CTRL}); end
      end
      ex_busy = 1'b0;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL busy_release got %b exp 0", stall); end
      checks++; if (stall_count !== 16'd3) begin errors++; $display("FAIL busy_count got %0d exp 3", stall_count); end
      step();
      checks++; if ({ex_rs, ex_rd, ex_ctrl} !== {5'd12, 5'd28, LW_CTRL}) begin errors++; $display("FAIL busy_resume got %h exp %h", {ex_rs, ex_rd, ex_ctrl}, {5'd12, 5'd28, LW_CTRL}); end
      // ex_rt is now 22 with a load in EX; a reader of $22 while busy holds without a bubble.
      set_id(1'b1, 5'd22, 5'd7, 5'd9, 1'b1, 1'b0, 32'h55, ADD_CTRL);
      ex_busy = 1'b1;
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL busyhaz_stall got %b exp 1", stall); end
      step();
      checks++; if ({ex_valid, ex_rt, ex_ctrl} !== {1'b1, 5'd22, LW_CTRL}) begin errors++; $display("FAIL busyhaz_hold got %h exp %h", {ex_valid, ex_rt, ex_ctrl}, {1'b1, 5'd22, LW_CTRL}); end
      ex_busy = 1'b0;
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL busyhaz_haz got %b exp 1", stall); end
      step();
      checks++; if ({ex_valid, ex_ctrl} !== 10'h0) begin errors++; $display("FAIL busyhaz_bubble got %h exp 000", {ex_valid, ex_ctrl}); end
      checks++; if (stall_count !== 16'd5) begin errors++; $display("FAIL busyhaz_count got %0d exp 5", stall_count); end
   endtask

   task automatic test_flush();
      do_reset();
      set_id(1'b1, 5'd2, 5'd8, 5'd0, 1'b1, 1'b0, 32'h9, LW_CTRL);
      step();
      set_id(1'b1, 5'd8, 5'd8, 5'd9, 1'b1, 1'b1, 32'hA, ADD_CTRL);
      ex_busy = 1'b1;
      flush = 1'b1;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got %b exp 0", stall); end
      step();
      checks++; if ({ex_valid, ex_rt, ex_ctrl} !== 15'h0) begin errors++; $display("FAIL flush_bubble got %h exp 0", {ex_valid, ex_rt, ex_ctrl}); end
      checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", stall_count); end
      flush = 1'b0;
      ex_busy = 1'b0;
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      set_id(1'b1, 5'd2, 5'd8, 5'd0, 1'b1, 1'b0, 32'h9, LW_CTRL);
      step();
      set_id(1'b1, 5'd8, 5'd1, 5'd9, 1'b1, 1'b0, 32'hA, ADD_CTRL);
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL midrst_pre got %b exp 1", stall); end
      rst_n = 1'b0;
      #1;
      checks++; if ({stall, ex_valid, ex_ctrl} !== 11'h0) begin errors++; $display("FAIL midrst_clear got %h exp 0", {stall, ex_valid, ex_ctrl}); end
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_saturation();
      do_reset();
      ex_busy = 1'b1;
      for (int i = 0; i < 15; i++) step();
      checks++; if (s_count !== 4'hF) begin errors++; $display("FAIL sat_reach got %h exp f", s_count); end
      for (int i = 0; i < 6; i++) step();
      checks++; if (s_count !== 4'hF) begin errors++; $display("FAIL sat_stick got %h exp f", s_count); end
      checks++; if (stall_count !== 16'd21) begin errors++; $display("FAIL sat_wide got %0d exp 21", stall_count); end
      ex_busy = 1'b0;
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_no_hazard();
      test_busy();
      test_flush();
      test_reset_mid_stall();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
